// File: rtl/avion_pkg.sv
// Shared Avion bus constants: widths, MMIO register map, host FSM states, CPU opcodes.
package avion_pkg;

  localparam int ADDRESS_WIDTH = 6;
  localparam int DATA_WIDTH    = 10;
  localparam int OPCODE_WIDTH  = 4;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LED = 6'd60;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_SW  = 6'd61;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_CYC = 6'd62;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_WRC = 6'd63;

  typedef enum logic [2:0] {
    H_IDLE,
    H_HOLD,
    H_ACCESS,
    H_ACK,
    H_WAITLOW
  } host_state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LOD = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

  // Instruction word is {opcode, operand address}.
  function automatic logic [DATA_WIDTH-1:0] avion_instr(
    input logic [OPCODE_WIDTH-1:0] op,
    input logic [ADDRESS_WIDTH-1:0] addr
  );
    return {op, addr};
  endfunction

endpackage

// File: rtl/avion_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module avion_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/avion_mem_responder.sv
// Avion memory target: CPU RAM + MMIO registers, with a host load/dump port
// that freezes the CPU via o_cpu_hold while it owns the memory.
module avion_mem_responder #(
  parameter int ADDRESS_WIDTH = avion_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = avion_pkg::DATA_WIDTH,
  parameter int DEPTH         = 64,
  parameter int MMIO_BASE     = 60,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_ram_data_in,
  output logic [DATA_WIDTH-1:0]    o_ram_data_out,
  input  logic                     h_req,
  input  logic                     h_we,
  input  logic [ADDRESS_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0]    h_wdata,
  output logic                     h_ack,
  output logic [DATA_WIDTH-1:0]    h_rdata,
  output logic                     o_cpu_hold,
  input  logic [DATA_WIDTH-1:0]    i_switches,
  output logic [DATA_WIDTH-1:0]    o_leds
);
  import avion_pkg::*;

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] A_RAM_END = ADDRESS_WIDTH'(MMIO_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] A_LED = ADDRESS_WIDTH'(MMIO_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] A_SW  = ADDRESS_WIDTH'(MMIO_BASE + 1);
  localparam logic [ADDRESS_WIDTH-1:0] A_CYC = ADDRESS_WIDTH'(MMIO_BASE + 2);
  localparam logic [ADDRESS_WIDTH-1:0] A_WRC = ADDRESS_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] ram [MMIO_BASE];

  host_state_t               state;
  logic [HCW-1:0]            hold_cnt;
  logic                      lat_we;
  logic [ADDRESS_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic [DATA_WIDTH-1:0]     cyc_cnt;
  logic [DATA_WIDTH-1:0]     wr_cnt;
  logic [DATA_WIDTH-1:0]     sw_sync;

  logic                      host_slot;
  logic                      cpu_slot;
  logic [ADDRESS_WIDTH-1:0]  acc_addr;
  logic                      acc_we;
  logic                      acc_ram;
  logic [DATA_WIDTH-1:0]     acc_wdata;
  logic [DATA_WIDTH-1:0]     acc_rdata;

  avion_sync2 #(.WIDTH(DATA_WIDTH)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_switches),
    .q   (sw_sync)
  );

  // Single access port: the CPU owns it in IDLE, the host only in ACCESS;
  // every other state leaves memory and o_ram_data_out untouched.
  always_comb begin
    host_slot = (state == H_ACCESS);
    cpu_slot  = (state == H_IDLE);
    acc_addr  = host_slot ? lat_addr  : i_addr;
    acc_wdata = host_slot ? lat_wdata : i_ram_data_in;
    acc_we    = host_slot ? lat_we    : (cpu_slot & i_we);
    acc_ram   = (acc_addr < A_RAM_END);
    acc_rdata = '0;
    if (acc_ram) begin
      acc_rdata = ram[acc_addr];
    end else begin
      case (acc_addr)
        A_LED:   acc_rdata = o_leds;
        A_SW:    acc_rdata = sw_sync;
        A_CYC:   acc_rdata = cyc_cnt;
        A_WRC:   acc_rdata = wr_cnt;
        default: acc_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc_we && acc_ram) ram[acc_addr] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt        <= '0;
      wr_cnt         <= '0;
      o_leds         <= '0;
      o_ram_data_out <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (acc_we && acc_ram && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
      if (acc_we && (acc_addr == A_LED))        o_leds <= acc_wdata;
      if (cpu_slot)                             o_ram_data_out <= acc_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= H_IDLE;
      hold_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      o_cpu_hold <= 1'b0;
      h_ack      <= 1'b0;
      h_rdata    <= '0;
    end else begin
      h_ack <= 1'b0;
      case (state)
        H_IDLE: begin
          if (h_req) begin
            lat_we     <= h_we;
            lat_addr   <= h_addr;
            lat_wdata  <= h_wdata;
            hold_cnt   <= '0;
            o_cpu_hold <= 1'b1;
            state      <= H_HOLD;
          end
        end
        H_HOLD: begin
          if (hold_cnt == HCW'(HOLD_CYCLES - 1)) state <= H_ACCESS;
          else                                   hold_cnt <= hold_cnt + 1'b1;
        end
        H_ACCESS: begin
          h_ack   <= 1'b1;
          h_rdata <= lat_we ? lat_wdata : acc_rdata;
          state   <= H_ACK;
        end
        H_ACK: state <= H_WAITLOW;
        H_WAITLOW: begin
          if (!h_req) begin
            o_cpu_hold <= 1'b0;
            state      <= H_IDLE;
          end
        end
        default: state <= H_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avion_mem_responder.sv
// Directed + randomized bench for avion_mem_responder against a word-level memory model.
module tb_avion_mem_responder;
  import avion_pkg::*;

  localparam int AW = 6;
  localparam int DW = 10;
  localparam int RAM_WORDS = 60;

  logic          clk;
  logic          rst;
  logic          i_we;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_ram_data_in;
  logic [DW-1:0] o_ram_data_out;
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  logic [DW-1:0] h_rdata;
  logic          o_cpu_hold;
  logic [DW-1:0] i_switches;
  logic [DW-1:0] o_leds;

  avion_mem_responder #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (64),
    .MMIO_BASE    (RAM_WORDS),
    .HOLD_CYCLES  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_we           (i_we),
    .i_addr         (i_addr),
    .i_ram_data_in  (i_ram_data_in),
    .o_ram_data_out (o_ram_data_out),
    .h_req          (h_req),
    .h_we           (h_we),
    .h_addr         (h_addr),
    .h_wdata        (h_wdata),
    .h_ack          (h_ack),
    .h_rdata        (h_rdata),
    .o_cpu_hold     (o_cpu_hold),
    .i_switches     (i_switches),
    .o_leds         (o_leds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain memory image, LED value and a total RAM-write tally.
  logic [DW-1:0] ram_m [RAM_WORDS];
  logic [DW-1:0] leds_m;
  int            wr_total;
  int            errors;
  int            checks;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int a);
    if (a < RAM_WORDS) return ram_m[a];
    if (a == int'(ADDR_LED)) return leds_m;
    return '0;
  endfunction

  function automatic int wrc_expected();
    return (wr_total > 1023) ? 1023 : wr_total;
  endfunction

  task automatic model_write(input int a, input logic [DW-1:0] d);
    if (a < RAM_WORDS) begin
      ram_m[a] = d;
      wr_total++;
    end else if (a == int'(ADDR_LED)) begin
      leds_m = d;
    end
  endtask

  task automatic cpu_read(input int a, output logic [DW-1:0] d);
    i_we   = 1'b0;
    i_addr = AW'(a);
    step();
    d = o_ram_data_out;
  endtask

  task automatic cpu_write(input int a, input logic [DW-1:0] d, output logic [DW-1:0] old);
    i_addr        = AW'(a);
    i_ram_data_in = d;
    i_we          = 1'b1;
    step();
    i_we = 1'b0;
    old  = o_ram_data_out;
    model_write(a, d);
  endtask

  // Host transaction; while the CPU is held it keeps trying to write a random
  // RAM word, which must never land.
  task automatic host_access(input logic we, input int a, input logic [DW-1:0] d,
                             output logic [DW-1:0] rd);
    int            lat;
    logic [DW-1:0] frozen;
    logic [DW-1:0] exp;
    exp     = we ? d : model_rd(a);
    h_req   = 1'b1;
    h_we    = we;
    h_addr  = AW'(a);
    h_wdata = d;
    step();
    i_we          = 1'b1;
    i_addr        = AW'($urandom_range(0, RAM_WORDS - 1));
    i_ram_data_in = DW'($urandom);
    check("hold_rise", o_cpu_hold, 1);
    frozen = o_ram_data_out;
    lat = 1;
    while (!h_ack && lat < 12) begin
      step();
      lat++;
    end
    check("ack_latency", lat, 4);
    rd = h_rdata;
    check("host_rdata", rd, exp);
    step();
    check("ack_one_cycle", h_ack, 0);
    check("rdata_held", h_rdata, rd);
    check("hold_until_req_low", o_cpu_hold, 1);
    i_we  = 1'b0;
    h_req = 1'b0;
    step();
    check("hold_release", o_cpu_hold, 0);
    check("dout_frozen", o_ram_data_out, frozen);
    if (we) model_write(a, d);
  endtask

  initial begin
    logic [DW-1:0] r;
    logic [DW-1:0] r2;
    logic [DW-1:0] e;
    logic [DW-1:0] acc;
    logic [DW-1:0] instr;
    int            pc;
    int            a;
    int            ack_seen;
    logic          halted;

    errors = 0;
    checks = 0;
    wr_total = 0;
    leds_m = '0;
    rst = 1'b1;
    i_we = 1'b0;
    i_addr = '0;
    i_ram_data_in = '0;
    h_req = 1'b0;
    h_we = 1'b0;
    h_addr = '0;
    h_wdata = '0;
    i_switches = '0;

    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_dout", o_ram_data_out, 0);
    check("rst_ack", h_ack, 0);
    check("rst_rdata", h_rdata, 0);
    check("rst_hold", o_cpu_hold, 0);
    check("rst_leds", o_leds, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < RAM_WORDS; i++) cpu_write(i, DW'($urandom), r);

    // Program load through the host port, then the bench plays the CPU.
    host_access(1'b1, 50, 10'd5, r);
    host_access(1'b1, 51, 10'd10, r);
    host_access(1'b1, 0, avion_instr(OP_LOD, 6'd50), r);
    host_access(1'b1, 1, avion_instr(OP_ADD, 6'd51), r);
    host_access(1'b1, 2, avion_instr(OP_STO, 6'd52), r);
    host_access(1'b1, 3, avion_instr(OP_HLT, 6'd0), r);
    pc = 0;
    acc = '0;
    halted = 1'b0;
    for (int n = 0; n < 16 && !halted; n++) begin
      cpu_read(pc, instr);
      case (instr[9:6])
        OP_LOD:  cpu_read(int'(instr[5:0]), acc);
        OP_ADD:  begin cpu_read(int'(instr[5:0]), r); acc = acc + r; end
        OP_STO:  cpu_write(int'(instr[5:0]), acc, r);
        default: halted = 1'b1;
      endcase
      pc++;
    end
    check("prog_halted", halted, 1);
    while ($time < 5000) step();
    host_access(1'b0, 52, '0, r);
    check("prog_sum", r, 15);

    cpu_write(3, 10'h240, r);
    cpu_read(3, r);
    check("cpu_read_3", r, 10'h240);
    e = model_rd(7);
    cpu_write(7, 10'h1AA, r);
    check("rdw_old", r, e);
    cpu_read(7, r);
    check("rdw_new", r, 10'h1AA);

    cpu_write(int'(ADDR_LED), 10'h3FF, r);
    check("led_write", o_leds, 10'h3FF);
    cpu_read(int'(ADDR_LED), r);
    check("led_readback", r, 10'h3FF);
    cpu_read(int'(ADDR_WRC), r);
    check("wrc_before_ro", r, wrc_expected());
    cpu_write(int'(ADDR_CYC), 10'h055, r);
    cpu_write(int'(ADDR_SW), 10'h0AA, r);
    cpu_read(int'(ADDR_WRC), r);
    check("wrc_ro_ignored", r, wrc_expected());

    cpu_read(int'(ADDR_SW), r);
    i_switches = 10'h155;
    step();
    check("sw_sync_1", o_ram_data_out, 0);
    step();
    check("sw_sync_2", o_ram_data_out, 0);
    step();
    check("sw_sync_3", o_ram_data_out, 10'h155);

    cpu_read(int'(ADDR_CYC), r);
    for (int i = 0; i < 1030; i++) step();
    r2 = o_ram_data_out;
    check("cyc_wrap", r2 - r, 6);

    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, RAM_WORDS - 1);
      e = model_rd(a);
      if (n % 10 == 9) begin
        host_access($urandom_range(0, 1) == 1, a, DW'($urandom), r);
      end else if ($urandom_range(0, 1) == 1) begin
        cpu_write(a, DW'($urandom), r);
        check("rnd_wr_old", r, e);
      end else begin
        cpu_read(a, r);
        check("rnd_rd", r, e);
      end
    end

    // CPU write in the same cycle h_req rises must land.
    i_we = 1'b1;
    i_addr = 6'd20;
    i_ram_data_in = 10'h123;
    model_write(20, 10'h123);
    host_access(1'b0, 20, '0, r);
    cpu_read(20, r);
    check("same_cycle_write", r, 10'h123);
    for (int i = 0; i < RAM_WORDS; i++) begin
      cpu_read(i, r);
      check("ram_sweep", r, ram_m[i]);
    end

    for (int i = 0; i < 1100; i++) cpu_write($urandom_range(0, RAM_WORDS - 1), DW'($urandom), r);
    cpu_read(int'(ADDR_WRC), r);
    check("wrc_saturate", r, wrc_expected());

    // Reset while a host write to 30 is in HOLD.
    e = model_rd(30);
    h_req = 1'b1;
    h_we = 1'b1;
    h_addr = 6'd30;
    h_wdata = ~e;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_mid_hold", o_cpu_hold, 0);
    check("rst_mid_ack", h_ack, 0);
    h_req = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) rst = 1'b1;
      if (h_ack) ack_seen++;
    end
    check("rst_no_ack", ack_seen, 0);
    leds_m = '0;
    wr_total = 0;
    check("rst_leds_clear", o_leds, leds_m);
    cpu_read(30, r);
    check("rst_write_lost", r, e);
    cpu_read(50, r);
    check("rst_ram_kept", r, model_rd(50));
    cpu_read(int'(ADDR_WRC), r);
    check("rst_wrc_clear", r, wrc_expected());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
